seven_segment_scanner: RTL

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode display bank. It is the successor to the single-digit direct-drive decoder. It latches a multi-digit hex value on a load strobe and decodes each nibble to segment patterns. It scans one digit per refresh slot, with a dead-time gap between slots to suppress ghosting, and mirrors the low byte of the latched value on the DIP-switch LEDs.

---
 rtl/seven_segment_scanner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with dead-time gaps between digit slots.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_segment_scanner #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dpMask,
  input  logic                  blank,
  output logic [7:0]            leds,
  output logic [7:0]            sevenSegmentData,
  output logic [DIGITS-1:0]     sevenSegmentEnable,
  output logic                  scanWrap
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_END = DIV_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [VAL_W-1:0]  held_value;
  logic [DIV_W-1:0]  div_count;
  logic [IDX_W-1:0]  digit_idx;

  logic [3:0]        nibble;
  logic              dp_sel;
  logic              suppress;
  logic [DIGITS-1:0] lz_mask;
  logic [6:0]        seg_on;
  logic [7:0]        data_next;
  logic [DIGITS-1:0] enable_next;
  logic              wrap_next;
  logic              in_dead;

  // Hex nibble to active-high gfedcba pattern.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is dark when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    lz_mask = '0;
    for (int i = 1; i < DIGITS; i++) begin
      lz_mask[i] = ((held_value >> (4 * i)) == '0);
    end
  end
`else
  always_comb begin
    lz_mask = '0;
  end
`endif

  // Select the active digit's nibble and flags, then form the next output words.
  always_comb begin
    nibble   = '0;
    dp_sel   = 1'b0;
    suppress = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        nibble   = held_value[4*i +: 4];
        dp_sel   = dpMask[i];
        suppress = lz_mask[i];
      end
    end
    seg_on    = decode(nibble);
    in_dead   = (div_count < DEAD_END);
    data_next = ~{dp_sel & ~suppress, seg_on};
    if (blank || in_dead || suppress) begin
      enable_next = '1;
    end else begin
      enable_next = ~(DIGITS'(1) << digit_idx);
    end
    wrap_next = (div_count == '0) && (digit_idx == '0);
  end

  // Held value, scan counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      held_value         <= '0;
      div_count          <= '0;
      digit_idx          <= '0;
      leds               <= 8'h00;
      sevenSegmentData   <= 8'hFF;
      sevenSegmentEnable <= '1;
      scanWrap           <= 1'b0;
    end else begin
      if (load) begin
        held_value <= value;
      end
      if (div_count == DIV_LAST) begin
        div_count <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        div_count <= div_count + DIV_W'(1);
      end
      leds               <= held_value[7:0];
      sevenSegmentData   <= data_next;
      sevenSegmentEnable <= enable_next;
      scanWrap           <= wrap_next;
    end
  end

endmodule
